pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch/PC controller for the single-cycle processor. It owns the program counter register and sequences each instruction through a fetch handshake with instruction memory, then an execute slot. The next PC is chosen from sequential, branch, jump or (optionally) trap sources. It sits between the control unit, which supplies branch/jump/halt decisions, and the instruction memory port.

## Interface
- `WIDTH`, 32: PC/address width in bits.
- `RESET_VECTOR`, 32'h0000_0000: PC value after reset.
- `TRAP_VECTOR`, 32'h0000_0080: trap target; exists only with `PC_SEQ_TRAP_EN`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pc`  out  WIDTH  current PC; this is also the fetch address.
- `imem_req`  out  1  fetch request; high throughout FETCH.
- `imem_ack`  in  1  instruction memory has returned the word at `pc` this cycle.
- `instr_valid`  out  1  instruction at `pc` retires this cycle.
- `stall`  in  1  hold the current instruction in EXEC.
- `branch_taken`  in  1  take the PC-relative branch.
- `branch_offset`  in  WIDTH  signed word offset.
- `jump`  in  1  take the absolute jump.
- `jump_target`  in  WIDTH  absolute byte address.
- `halt`  in  1  stop sequencing.
- `halted`  out  1  high while in HALT.
- `trap`  in  1  take a trap (macro only).
- `epc`  out  WIDTH  PC of the trapping instruction (macro only).

## Operation
- State machine, 2-bit encoding: BOOT, FETCH, EXEC, HALT.
- Reset (asynchronous, `rst_n`=0) forces:
  - state=BOOT, `pc`=RESET_VECTOR, `epc`=0;
  - `imem_req`=0, `instr_valid`=0, `halted`=0.
- BOOT: one idle cycle, then FETCH unconditionally.
- FETCH: `imem_req`=1 and `pc` is held stable.
  - `imem_ack`=1: go to EXEC.
  - otherwise: stay in FETCH.
  - `imem_ack` is ignored in every other state.
- EXEC with `stall`=1: stay in EXEC, `instr_valid`=0, all control inputs ignored.
- EXEC with `stall`=0: `instr_valid`=1 and the control inputs are sampled. Priority, highest first:
  - `halt`: go to HALT, `pc` unchanged.
  - `trap` (macro only): `epc`←`pc`, `pc`←TRAP_VECTOR, go to FETCH.
  - `jump`: `pc`←{`jump_target`[WIDTH-1:2], 2'b00}, go to FETCH.
  - `branch_taken`: `pc`←`pc`+4+(`branch_offset`<<2), go to FETCH.
  - none of the above: `pc`←`pc`+4, go to FETCH.
- HALT: `halted`=1, `imem_req`=0, `pc` frozen. The only exit is reset.
- Arithmetic: all PC arithmetic is modulo 2^WIDTH. `branch_offset` is two's complement, the shift discards its top 2 bits, and no overflow is flagged.
- `pc`[1:0] is always 00. RESET_VECTOR and TRAP_VECTOR must be word-aligned.

## Timing
- Output decode:
  - `imem_req` and `halted` are Moore decodes of state.
  - `instr_valid` = (state==EXEC) & !`stall`, combinational on `stall`.
- The `pc` update lands on the same rising edge that retires the instruction (EXEC with `stall`=0).
- Minimum instruction period is 2 cycles (FETCH with immediate ack, then EXEC). Each wait cycle or stall cycle adds 1.
- First fetch: `imem_req` rises in cycle 2 after `rst_n` deasserts (BOOT occupies cycle 1).
- Reset asserted mid-FETCH or mid-EXEC takes effect immediately and without an edge; the pending instruction is dropped.
- Simultaneous `jump`+`branch_taken`: jump wins. Simultaneous `halt`+anything: halt wins.

## Configuration
- `PC_SEQ_TRAP_EN` defined:
  - `trap`, `epc` and TRAP_VECTOR exist.
  - Trap sits in the priority order directly below halt.
- `PC_SEQ_TRAP_EN` undefined:
  - the ports and parameter are absent;
  - priority is halt > jump > branch > sequential;
  - behaviour is otherwise identical.

## Structure
- Shared package `pc_seq_pkg` holds:
  - state encodings BOOT=0, FETCH=1, EXEC=2, HALT=3;
  - INSTR_BYTES=4;
  - next-PC select codes (SEQ, BRANCH, JUMP, TRAP).
- Sub-module `pc_next_mux` is purely combinational: it takes `pc`, the select code and the targets and produces the next PC. The FSM and the PC register stay in `pc_sequencer`.

## Test plan
- Sequential fetch: reset with RESET_VECTOR=0, `imem_ack` tied 1, no controls → `pc` = 0, 4, 8, 12, with `instr_valid` pulsing every 2nd cycle.
- Wait states and stall: `imem_ack` low 3 cycles, then `stall` high 2 cycles in EXEC → `pc` is held at 0x10 for the whole period, `instr_valid` pulses once, then `pc`=0x14.
- Branch and wrap: at `pc`=0x20, `branch_offset`=-3 → `pc`=0x18. At `pc`=0xFFFF_FFFC, sequential → `pc`=0x0000_0000.
- Priority: `jump`=1 with `jump_target`=0x0000_1003, plus `branch_taken`=1 → `pc`=0x0000_1000. Then `halt`+`jump` → `halted`=1, `pc`=0x1000, `imem_req`=0 forever.
- Reset mid-operation: drop `rst_n` while in FETCH at `pc`=0x40 → `pc`=RESET_VECTOR and `imem_req`=0 immediately. After release, one BOOT cycle, then `imem_req`=1.
- With `PC_SEQ_TRAP_EN`: `trap` at `pc`=0x30 → `epc`=0x30, `pc`=0x80. `trap`+`halt` together → HALT, `epc` unchanged.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared encodings for the PC sequencer: FSM states, next-PC select codes, instruction size.
package pc_seq_pkg;

    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned STATE_W     = 2;
    localparam int unsigned SEL_W       = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    typedef enum logic [SEL_W-1:0] {
        SEL_SEQ    = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_JUMP   = 2'd2,
        SEL_TRAP   = 2'd3
    } pc_sel_e;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection: sequential, PC-relative branch, absolute jump or trap vector.
module pc_next_mux
    import pc_seq_pkg::*;
#(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] TRAP_VECTOR = WIDTH'(32'h0000_0080)
) (
    input  logic [WIDTH-1:0] pc_i,
    input  pc_sel_e          sel_i,
    input  logic [WIDTH-1:0] branch_offset_i,
    input  logic [WIDTH-1:0] jump_target_i,
    output logic [WIDTH-1:0] pc_next_c_o
);

    logic [WIDTH-1:0] seq_pc;

    // Fall-through address; branch targets are relative to it.
    assign seq_pc = pc_i + WIDTH'(INSTR_BYTES);

    // Select the next PC; the word shift drops the offset's top two bits (modulo arithmetic).
    always_comb begin
        pc_next_c_o = seq_pc;
        case (sel_i)
            SEL_SEQ:    pc_next_c_o = seq_pc;
            SEL_BRANCH: pc_next_c_o = seq_pc + (branch_offset_i << 2);
            SEL_JUMP:   pc_next_c_o = jump_target_i & ~WIDTH'(INSTR_BYTES - 1);
            SEL_TRAP:   pc_next_c_o = TRAP_VECTOR;
            default:    pc_next_c_o = seq_pc;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/PC controller: owns the PC, runs the FETCH handshake and EXEC slot, picks the next PC.
// Optional trap support (trap input, epc output, TRAP_VECTOR) is enabled by defining PC_SEQ_TRAP_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_0000)
`ifdef PC_SEQ_TRAP_EN
    ,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0080)
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             imem_ack,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_offset,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             halt,
`ifdef PC_SEQ_TRAP_EN
    input  logic             trap,
    output logic [WIDTH-1:0] epc,
`endif
    output logic [WIDTH-1:0] pc,
    output logic             imem_req,
    output logic             instr_valid,
    output logic             halted
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_next;
    pc_sel_e          sel;
    logic             imem_req_q;
    logic             halted_q;
    logic             instr_valid_c;
`ifdef PC_SEQ_TRAP_EN
    logic [WIDTH-1:0] epc_q, epc_d;
`endif

    // Next-PC datapath.
    pc_next_mux #(
        .WIDTH           (WIDTH)
`ifdef PC_SEQ_TRAP_EN
        ,
        .TRAP_VECTOR     (TRAP_VECTOR)
`endif
    ) u_pc_next_mux (
        .pc_i            (pc_q),
        .sel_i           (sel),
        .branch_offset_i (branch_offset),
        .jump_target_i   (jump_target),
        .pc_next_c_o     (pc_next)
    );

    // Next-state, PC update and retire decode; control inputs only matter on an unstalled EXEC.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        sel           = SEL_SEQ;
        instr_valid_c = 1'b0;
`ifdef PC_SEQ_TRAP_EN
        epc_d         = epc_q;
`endif
        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    instr_valid_c = 1'b1;
                    if (halt) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_FETCH;
                        if (jump) begin
                            sel = SEL_JUMP;
                        end else if (branch_taken) begin
                            sel = SEL_BRANCH;
                        end
`ifdef PC_SEQ_TRAP_EN
                        // Trap outranks jump/branch; only halt beats it.
                        if (trap) begin
                            sel   = SEL_TRAP;
                            epc_d = pc_q;
                        end
`endif
                        pc_d = pc_next;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State, PC and Moore-output registers; outputs are loaded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            imem_req_q <= 1'b0;
            halted_q   <= 1'b0;
`ifdef PC_SEQ_TRAP_EN
            epc_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            imem_req_q <= (state_d == ST_FETCH);
            halted_q   <= (state_d == ST_HALT);
`ifdef PC_SEQ_TRAP_EN
            epc_q      <= epc_d;
`endif
        end
    end

    assign pc          = pc_q;
    assign imem_req    = imem_req_q;
    assign halted      = halted_q;
    assign instr_valid = instr_valid_c;
`ifdef PC_SEQ_TRAP_EN
    assign epc         = epc_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized instruction streams
// checked against an instruction-level reference model. Trap checks compile with PC_SEQ_TRAP_EN.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_ack;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [31:0] jump_target;
    logic        halt;
    logic [31:0] pc;
    logic        imem_req;
    logic        instr_valid;
    logic        halted;
`ifdef PC_SEQ_TRAP_EN
    logic        trap;
    logic [31:0] epc;
`endif

    int          checks = 0;
    int          passes = 0;
    int          fails  = 0;
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic        m_halted;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_ack      (imem_ack),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_target   (jump_target),
        .halt          (halt),
`ifdef PC_SEQ_TRAP_EN
        .trap          (trap),
        .epc           (epc),
`endif
        .pc            (pc),
        .imem_req      (imem_req),
        .instr_valid   (instr_valid),
        .halted        (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_ctl();
        imem_ack      = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = '0;
        jump          = 1'b0;
        jump_target   = '0;
        halt          = 1'b0;
`ifdef PC_SEQ_TRAP_EN
        trap          = 1'b0;
`endif
    endtask

    // Random values on control inputs that must be ignored outside an unstalled EXEC.
    task automatic junk_ctl();
        branch_taken  = 1'($urandom_range(0, 1));
        branch_offset = $urandom;
        jump          = 1'($urandom_range(0, 1));
        jump_target   = $urandom;
        halt          = 1'($urandom_range(0, 1));
`ifdef PC_SEQ_TRAP_EN
        trap          = 1'($urandom_range(0, 1));
`endif
    endtask

    // Reference model for one retired instruction, straight from the priority rules.
    task automatic model_retire(input logic h, input logic tr, input logic j,
                                input logic [31:0] jt, input logic b, input logic [31:0] bo);
        if (h)       m_halted = 1'b1;
        else if (tr) begin m_epc = m_pc; m_pc = 32'h0000_0080; end
        else if (j)  m_pc = jt & 32'hFFFF_FFFC;
        else if (b)  m_pc = m_pc + 32'd4 + (bo << 2);
        else         m_pc = m_pc + 32'd4;
    endtask

    // One instruction: (waits+1) FETCH cycles, 'stalls' stalled EXEC cycles, one retire cycle.
    task automatic run_instr(input int waits, input int stalls, input logic h, input logic tr,
                             input logic j, input logic [31:0] jt, input logic b,
                             input logic [31:0] bo);
        for (int i = 0; i <= waits; i++) begin
            @(negedge clk);
            clear_ctl();
            junk_ctl();
            stall    = 1'($urandom_range(0, 1));
            imem_ack = (i == waits);
            #1;
            chk("fetch_req", 32'(imem_req), 32'd1);
            chk("fetch_pc", pc, m_pc);
            chk("fetch_valid", 32'(instr_valid), 32'd0);
        end
        for (int k = 0; k < stalls; k++) begin
            @(negedge clk);
            junk_ctl();
            imem_ack = 1'($urandom_range(0, 1));
            stall    = 1'b1;
            #1;
            chk("stall_valid", 32'(instr_valid), 32'd0);
            chk("stall_req", 32'(imem_req), 32'd0);
            chk("stall_pc", pc, m_pc);
        end
        @(negedge clk);
        clear_ctl();
        imem_ack      = 1'($urandom_range(0, 1));
        halt          = h;
        jump          = j;
        jump_target   = jt;
        branch_taken  = b;
        branch_offset = bo;
`ifdef PC_SEQ_TRAP_EN
        trap          = tr;
`endif
        #1;
        chk("retire_valid", 32'(instr_valid), 32'd1);
        chk("retire_pc", pc, m_pc);
        chk("retire_halted", 32'(halted), 32'd0);
        model_retire(h, tr, j, jt, b, bo);
    endtask

    // Check the PC just after the edge that follows a retire.
    task automatic post_chk(input string tag, input logic [31:0] exp);
        @(posedge clk);
        #1;
        chk(tag, pc, exp);
    endtask

    initial begin
        logic tr_r;
        rst_n    = 1'b0;
        clear_ctl();
        m_pc     = 32'h0;
        m_epc    = 32'h0;
        m_halted = 1'b0;
        tr_r     = 1'b0;

        // Reset values.
        #2;
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
`ifdef PC_SEQ_TRAP_EN
        chk("rst_epc", epc, 32'h0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("boot_req", 32'(imem_req), 32'd0);
        chk("boot_pc", pc, 32'h0);

        // Sequential fetch with immediate acks: 0, 4, 8, 12.
        for (int n = 0; n < 4; n++) run_instr(0, 0, 0, 0, 0, 0, 0, 0);
        post_chk("seq_pc", 32'h10);

        // Wait states and stalls hold the PC at 0x10.
        run_instr(3, 2, 0, 0, 0, 0, 0, 0);
        post_chk("wait_stall_pc", 32'h14);

        // Walk to 0x20 and branch back by three words.
        for (int n = 0; n < 3; n++) run_instr(0, 0, 0, 0, 0, 0, 0, 0);
        run_instr(0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFD);
        post_chk("branch_neg_pc", 32'h18);

        // Sequential wrap at the top of the address space.
        run_instr(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        run_instr(0, 1, 0, 0, 0, 0, 0, 0);
        post_chk("wrap_pc", 32'h0);

        // Jump beats branch and drops the low target bits.
        run_instr(0, 0, 0, 0, 1, 32'h0000_1003, 1, 32'h5);
        post_chk("jump_prio_pc", 32'h1000);

        // Asynchronous reset in the middle of FETCH at 0x40.
        run_instr(0, 0, 0, 0, 1, 32'h0000_0040, 0, 0);
        @(negedge clk);
        clear_ctl();
        #1;
        chk("pre_rst_pc", pc, 32'h40);
        chk("pre_rst_req", 32'(imem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_pc  = 32'h0;
        #1;
        chk("reboot_req", 32'(imem_req), 32'd0);

`ifdef PC_SEQ_TRAP_EN
        // Trap at 0x30 records the PC and vectors.
        run_instr(0, 0, 0, 0, 1, 32'h0000_0030, 0, 0);
        run_instr(0, 0, 0, 1, 1, 32'h0000_0500, 1, 32'h7);
        post_chk("trap_pc", 32'h80);
        chk("trap_epc", epc, 32'h30);
`endif

        // Randomized instruction stream against the model.
        for (int n = 0; n < 40; n++) begin
`ifdef PC_SEQ_TRAP_EN
            tr_r = ($urandom_range(0, 7) == 0);
`endif
            run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0, tr_r,
                      ($urandom_range(0, 3) == 0), $urandom, 1'($urandom_range(0, 1)), $urandom);
`ifdef PC_SEQ_TRAP_EN
            #1;
            chk("rand_epc", epc, m_epc);
`endif
        end

        // Halt together with every other control: halt wins, PC and EPC frozen.
        run_instr(1, 1, 1, 1'b1, 1, 32'h0000_2000, 1, 32'h9);
        post_chk("halt_pc", m_pc);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            clear_ctl();
            junk_ctl();
            imem_ack = 1'b1;
            #1;
            chk("halt_halted", 32'(halted), 32'(m_halted));
            chk("halt_req", 32'(imem_req), 32'd0);
            chk("halt_valid", 32'(instr_valid), 32'd0);
            chk("halt_hold_pc", pc, m_pc);
`ifdef PC_SEQ_TRAP_EN
            chk("halt_epc", epc, m_epc);
`endif
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
